// File: rtl/shifter8_deser_if.sv
// Serial-side and parallel-side handshake bundle for the shifter8_deser receiver.
interface shifter8_deser_if;
    logic       clear;
    logic       s_valid;
    logic       s_data;
    logic       s_ready;
    logic       p_valid;
    logic       p_ready;
    logic [7:0] p_data;
    logic       p_perr;
    logic [3:0] bit_cnt;

    modport master (
        output clear, s_valid, s_data, p_ready,
        input  s_ready, p_valid, p_data, p_perr, bit_cnt
    );

    modport slave (
        input  clear, s_valid, s_data, p_ready,
        output s_ready, p_valid, p_data, p_perr, bit_cnt
    );
endinterface

// File: rtl/shifter8_deser.sv
// Serial-in, parallel-out 8-bit receiver with a one-byte holding stage.
// Define SHIFTER8_DESER_PARITY_EN for 9-bit frames ending in an even-parity bit.
module shifter8_deser #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    shifter8_deser_if.slave  bus
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;
`ifdef SHIFTER8_DESER_PARITY_EN
    localparam int unsigned FRAME_LEN = 9;
`else
    localparam int unsigned FRAME_LEN = 8;
`endif
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    localparam logic [0:0] SHIFT = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    logic [0:0]        state, state_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [DATA_W-1:0] pdata, pdata_n;
    logic              pvalid, pvalid_n;
    logic              pperr, pperr_n;
    logic              hold_perr, hold_perr_n;
    logic              ready_q, ready_n;

    logic              accept;
    logic              out_free;
    logic              last_bit;
    logic              data_bit;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] frame_byte;
    logic              frame_perr;

    assign accept   = bus.s_valid & ready_q;
    assign out_free = ~pvalid | bus.p_ready;
    assign last_bit = (cnt == LAST_IDX);
    assign shifted  = LSB_FIRST ? {bus.s_data, shreg[DATA_W-1:1]}
                                : {shreg[DATA_W-2:0], bus.s_data};

    // With parity the last bit only feeds the error flag; the byte is already complete.
`ifdef SHIFTER8_DESER_PARITY_EN
    assign data_bit   = ~last_bit;
    assign frame_byte = shreg;
    assign frame_perr = (^shreg) ^ bus.s_data;
`else
    assign data_bit   = 1'b1;
    assign frame_byte = shifted;
    assign frame_perr = 1'b0;
`endif

    // Next-state and output-stage logic
    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        cnt_n       = cnt;
        pdata_n     = pdata;
        pvalid_n    = pvalid;
        pperr_n     = pperr;
        hold_perr_n = hold_perr;

        if (pvalid & bus.p_ready) begin
            pvalid_n = 1'b0;
        end

        if (bus.clear) begin
            shreg_n = '0;
            cnt_n   = '0;
            state_n = SHIFT;
        end else begin
            case (state)
                SHIFT: begin
                    if (accept) begin
                        if (data_bit) begin
                            shreg_n = shifted;
                        end
                        if (last_bit) begin
                            cnt_n = '0;
                            if (out_free) begin
                                pdata_n  = frame_byte;
                                pperr_n  = frame_perr;
                                pvalid_n = 1'b1;
                                shreg_n  = '0;
                            end else begin
                                shreg_n     = frame_byte;
                                hold_perr_n = frame_perr;
                                state_n     = HOLD;
                            end
                        end else begin
                            cnt_n = cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    // Parked byte moves out as soon as the output stage frees up
                    if (out_free) begin
                        pdata_n  = shreg;
                        pperr_n  = hold_perr;
                        pvalid_n = 1'b1;
                        shreg_n  = '0;
                        state_n  = SHIFT;
                    end
                end
                default: begin
                    state_n = SHIFT;
                end
            endcase
        end

        ready_n = (state_n == SHIFT);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SHIFT;
            shreg     <= '0;
            cnt       <= '0;
            pdata     <= '0;
            pvalid    <= 1'b0;
            pperr     <= 1'b0;
            hold_perr <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            cnt       <= cnt_n;
            pdata     <= pdata_n;
            pvalid    <= pvalid_n;
            pperr     <= pperr_n;
            hold_perr <= hold_perr_n;
            ready_q   <= ready_n;
        end
    end

    assign bus.s_ready = ready_q;
    assign bus.p_valid = pvalid;
    assign bus.p_data  = pdata;
    assign bus.p_perr  = pperr;
    assign bus.bit_cnt = cnt;
endmodule

// File: tb/tb_shifter8_deser.sv
// Bench for shifter8_deser: LSB-first and MSB-first instances driven in lockstep
// against a queue-based reference model.
module tb_shifter8_deser;
`ifdef SHIFTER8_DESER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic clk;
    logic reset;
    logic s_valid, s_data, p_ready, clear;

    shifter8_deser_if bus_l ();
    shifter8_deser_if bus_m ();

    assign bus_l.s_valid = s_valid;
    assign bus_l.s_data  = s_data;
    assign bus_l.p_ready = p_ready;
    assign bus_l.clear   = clear;
    assign bus_m.s_valid = s_valid;
    assign bus_m.s_data  = s_data;
    assign bus_m.p_ready = p_ready;
    assign bus_m.clear   = clear;

    shifter8_deser #(.LSB_FIRST(1'b1)) dut_l (.clk(clk), .reset(reset), .bus(bus_l));
    shifter8_deser #(.LSB_FIRST(1'b0)) dut_m (.clk(clk), .reset(reset), .bus(bus_m));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: bits of the open frame plus a queue of delivered/parked bytes {perr, data}
    logic       bits [$];
    logic [8:0] qa [$];
    logic [8:0] qb [$];

    logic [14:0] ol, el, om, em;

    function automatic void model_reset();
        bits.delete();
        qa.delete();
        qb.delete();
    endfunction

    function automatic void push_frame();
        logic [7:0] a;
        logic [7:0] b;
        logic       pe;
        for (int i = 0; i < 8; i++) begin
            a[i]     = bits[i];
            b[7 - i] = bits[i];
        end
`ifdef SHIFTER8_DESER_PARITY_EN
        pe = (^a) ^ bits[8];
`else
        pe = 1'b0;
`endif
        qa.push_back({pe, a});
        qb.push_back({pe, b});
    endfunction

    // One clock edge of the model: at most two bytes in flight (output + parked)
    function automatic void model_step();
        int  sz;
        logic rdy;
        sz  = qa.size();
        rdy = (sz < 2);
        if (sz > 0 && p_ready) begin
            void'(qa.pop_front());
            void'(qb.pop_front());
        end
        if (clear) begin
            if (sz == 2) begin
                void'(qa.pop_back());
                void'(qb.pop_back());
            end
            bits.delete();
        end else if (s_valid && rdy) begin
            bits.push_back(s_data);
            if (bits.size() == NB) begin
                push_frame();
                bits.delete();
            end
        end
    endfunction

    function automatic logic [14:0] exp_vec(input int sz, input logic [8:0] h);
        return {(sz < 2), (sz > 0), (sz > 0) ? h[7:0] : 8'h00,
                (sz > 0) ? h[8] : 1'b0, 4'(bits.size())};
    endfunction

    function automatic logic [14:0] exp_l();
        return exp_vec(qa.size(), (qa.size() > 0) ? qa[0] : 9'h000);
    endfunction

    function automatic logic [14:0] exp_m();
        return exp_vec(qb.size(), (qb.size() > 0) ? qb[0] : 9'h000);
    endfunction

    function automatic logic [14:0] obs_l();
        return {bus_l.s_ready, bus_l.p_valid, bus_l.p_valid ? bus_l.p_data : 8'h00,
                bus_l.p_valid ? bus_l.p_perr : 1'b0, bus_l.bit_cnt};
    endfunction

    function automatic logic [14:0] obs_m();
        return {bus_m.s_ready, bus_m.p_valid, bus_m.p_valid ? bus_m.p_data : 8'h00,
                bus_m.p_valid ? bus_m.p_perr : 1'b0, bus_m.bit_cnt};
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7 - i] = x[i];
        return r;
    endfunction

    // Drive one cycle of stimulus from a falling edge; returns at the next falling edge
    task automatic step(input logic v, input logic d, input logic pr, input logic cl);
        s_valid = v;
        s_data  = d;
        p_ready = pr;
        clear   = cl;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        s_valid = 1'b0; s_data = 1'b0; p_ready = 1'b0; clear = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        checks += 6;
        if (bus_l.p_data !== 8'h00) begin errors++; $display("FAIL reset_p_data got=%h exp=00", bus_l.p_data); end
        if (bus_l.p_valid !== 1'b0) begin errors++; $display("FAIL reset_p_valid got=%b exp=0", bus_l.p_valid); end
        if (bus_l.s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got=%b exp=1", bus_l.s_ready); end
        if (bus_l.bit_cnt !== 4'd0) begin errors++; $display("FAIL reset_bit_cnt got=%0d exp=0", bus_l.bit_cnt); end
        if (bus_l.p_perr !== 1'b0) begin errors++; $display("FAIL reset_p_perr got=%b exp=0", bus_l.p_perr); end
        if ({bus_m.p_data, bus_m.p_valid, bus_m.s_ready, bus_m.bit_cnt, bus_m.p_perr} !== {8'h00, 1'b0, 1'b1, 4'd0, 1'b0}) begin
            errors++; $display("FAIL reset_msb got=%h exp=%h",
                {bus_m.p_data, bus_m.p_valid, bus_m.s_ready, bus_m.bit_cnt, bus_m.p_perr}, {8'h00, 1'b0, 1'b1, 4'd0, 1'b0});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_bit_order();
        logic [8:0] f;
        f = {^8'hA5, 8'hA5};
        for (int i = 0; i < NB; i++) begin
            step(1'b1, f[i], 1'b1, 1'b0);
            ol = obs_l(); el = exp_l(); om = obs_m(); em = exp_m();
            checks += 2;
            if (ol !== el) begin errors++; $display("FAIL order_a5_lsb got=%h exp=%h", ol, el); end
            if (om !== em) begin errors++; $display("FAIL order_a5_msb got=%h exp=%h", om, em); end
        end
        checks += 3;
        if (bus_l.p_valid !== 1'b1 || bus_l.p_data !== 8'hA5) begin errors++; $display("FAIL a5_lsb got=%b/%h exp=1/a5", bus_l.p_valid, bus_l.p_data); end
        if (bus_m.p_data !== 8'hA5) begin errors++; $display("FAIL a5_msb got=%h exp=a5", bus_m.p_data); end
        if (bus_l.bit_cnt !== 4'd0) begin errors++; $display("FAIL a5_bit_cnt got=%0d exp=0", bus_l.bit_cnt); end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus_l.p_valid !== 1'b0) begin errors++; $display("FAIL a5_one_cycle got=%b exp=0", bus_l.p_valid); end

        f = {^8'h01, 8'h01};
        for (int i = 0; i < NB; i++) step(1'b1, f[i], 1'b1, 1'b0);
        checks += 2;
        if (bus_l.p_data !== 8'h01) begin errors++; $display("FAIL x01_lsb got=%h exp=01", bus_l.p_data); end
        if (bus_m.p_data !== 8'h80) begin errors++; $display("FAIL x01_msb got=%h exp=80", bus_m.p_data); end
        step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        logic [8:0] f;
        f = {^8'h3C, 8'h3C};
        for (int i = 0; i < NB; i++) step(1'b1, f[i], 1'b0, 1'b0);
        f = {^8'hC3, 8'hC3};
        for (int i = 0; i < NB; i++) step(1'b1, f[i], 1'b0, 1'b0);
        checks += 3;
        if (bus_l.p_data !== 8'h3C || bus_l.p_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_data got=%b/%h exp=1/3c", bus_l.p_valid, bus_l.p_data); end
        if (bus_l.s_ready !== 1'b0) begin errors++; $display("FAIL bp_s_ready got=%b exp=0", bus_l.s_ready); end
        if (bus_m.p_data !== 8'h3C) begin errors++; $display("FAIL bp_hold_msb got=%h exp=3c", bus_m.p_data); end
        // Bits offered while stalled must be ignored
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'($urandom), 1'b0, 1'b0);
            ol = obs_l(); el = exp_l();
            checks++;
            if (ol !== el) begin errors++; $display("FAIL bp_stall got=%h exp=%h", ol, el); end
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks += 2;
        if (bus_l.p_data !== 8'hC3 || bus_l.p_valid !== 1'b1) begin errors++; $display("FAIL bp_drain_data got=%b/%h exp=1/c3", bus_l.p_valid, bus_l.p_data); end
        if (bus_l.s_ready !== 1'b1) begin errors++; $display("FAIL bp_drain_ready got=%b exp=1", bus_l.s_ready); end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus_l.p_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got=%b exp=0", bus_l.p_valid); end
    endtask

    task automatic test_gaps();
        logic [8:0] f;
        int idx = 0;
        int k = 0;
        logic v;
        f = {^8'h5A, 8'h5A};
        while (idx < NB && k < 100) begin
            v = (k % 4 == 0) || (k % 4 == 3);
            step(v, f[idx], 1'b1, 1'b0);
            if (v) idx++;
            k++;
            ol = obs_l(); el = exp_l(); om = obs_m(); em = exp_m();
            checks += 2;
            if (ol !== el) begin errors++; $display("FAIL gaps_lsb got=%h exp=%h", ol, el); end
            if (om !== em) begin errors++; $display("FAIL gaps_msb got=%h exp=%h", om, em); end
        end
        checks++;
        if (bus_l.p_data !== 8'h5A || bus_l.p_valid !== 1'b1) begin errors++; $display("FAIL gaps_byte got=%b/%h exp=1/5a", bus_l.p_valid, bus_l.p_data); end
        step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_clear();
        logic [7:0] r;
        logic [8:0] f;
        for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom), 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (bus_l.bit_cnt !== 4'd0) begin errors++; $display("FAIL clear_bit_cnt got=%0d exp=0", bus_l.bit_cnt); end
        r = 8'($urandom);
        f = {1'($urandom), r};
        for (int i = 0; i < NB; i++) step(1'b1, f[i], 1'b1, 1'b0);
        checks += 2;
        if (bus_l.p_data !== r) begin errors++; $display("FAIL clear_next_lsb got=%h exp=%h", bus_l.p_data, r); end
        if (bus_m.p_data !== rev8(r)) begin errors++; $display("FAIL clear_next_msb got=%h exp=%h", bus_m.p_data, rev8(r)); end
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Clear while a byte is parked discards it but keeps the presented byte
        f = {^8'h11, 8'h11};
        for (int i = 0; i < NB; i++) step(1'b1, f[i], 1'b0, 1'b0);
        f = {^8'h22, 8'h22};
        for (int i = 0; i < NB; i++) step(1'b1, f[i], 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks += 2;
        if (bus_l.s_ready !== 1'b1) begin errors++; $display("FAIL clear_hold_ready got=%b exp=1", bus_l.s_ready); end
        if (bus_l.p_valid !== 1'b1 || bus_l.p_data !== 8'h11) begin errors++; $display("FAIL clear_hold_keep got=%b/%h exp=1/11", bus_l.p_valid, bus_l.p_data); end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus_l.p_valid !== 1'b0) begin errors++; $display("FAIL clear_hold_drop got=%b exp=0", bus_l.p_valid); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step(($urandom % 4) != 0, 1'($urandom), ($urandom % 3) != 0, ($urandom % 50) == 0);
            ol = obs_l(); el = exp_l(); om = obs_m(); em = exp_m();
            checks += 2;
            if (ol !== el) begin errors++; $display("FAIL random_lsb n=%0d got=%h exp=%h", n, ol, el); end
            if (om !== em) begin errors++; $display("FAIL random_msb n=%0d got=%h exp=%h", n, om, em); end
        end
    endtask

`ifdef SHIFTER8_DESER_PARITY_EN
    task automatic test_parity();
        logic [8:0] f;
        f = {1'b0, 8'hA5};
        for (int i = 0; i < NB; i++) step(1'b1, f[i], 1'b1, 1'b0);
        checks++;
        if (bus_l.p_perr !== 1'b0 || bus_l.p_data !== 8'hA5) begin errors++; $display("FAIL parity_ok got=%b/%h exp=0/a5", bus_l.p_perr, bus_l.p_data); end
        f = {1'b1, 8'hA5};
        for (int i = 0; i < NB; i++) step(1'b1, f[i], 1'b1, 1'b0);
        checks += 2;
        if (bus_l.p_perr !== 1'b1 || bus_l.p_data !== 8'hA5) begin errors++; $display("FAIL parity_err got=%b/%h exp=1/a5", bus_l.p_perr, bus_l.p_data); end
        if (bus_m.p_perr !== 1'b1) begin errors++; $display("FAIL parity_err_msb got=%b exp=1", bus_m.p_perr); end
        step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask
`endif

    task automatic test_async_reset();
        logic [8:0] f;
        f = {^8'h96, 8'h96};
        for (int i = 0; i < NB; i++) step(1'b1, f[i], 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        checks += 2;
        if ({bus_l.p_valid, bus_l.p_data, bus_l.bit_cnt, bus_l.s_ready, bus_l.p_perr} !== {1'b0, 8'h00, 4'd0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL async_reset_lsb got=%h exp=%h",
                {bus_l.p_valid, bus_l.p_data, bus_l.bit_cnt, bus_l.s_ready, bus_l.p_perr}, {1'b0, 8'h00, 4'd0, 1'b1, 1'b0});
        end
        if ({bus_m.p_valid, bus_m.p_data, bus_m.bit_cnt} !== {1'b0, 8'h00, 4'd0}) begin
            errors++; $display("FAIL async_reset_msb got=%h exp=%h", {bus_m.p_valid, bus_m.p_data, bus_m.bit_cnt}, {1'b0, 8'h00, 4'd0});
        end
        @(negedge clk);
        reset = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_bit_order();
        test_backpressure();
        test_gaps();
        test_clear();
`ifdef SHIFTER8_DESER_PARITY_EN
        test_parity();
`endif
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/shifter8_deser.md
Name: shifter8_deser

Overview:
- Serial-in, parallel-out 8-bit receiver.
- Counterpart of the 8-bit shifter/serializer in the counter_shifter group: it reassembles the bit stream that the shifter emits back into bytes.
- Accepts one bit per valid/ready transfer, counts bits per frame and presents each completed byte on a registered parallel port with valid/ready handshake.
- One-byte holding stage provides backpressure to the serial side.

Parameters:
- LSB_FIRST, 1: 1 = first received bit lands in p_data[0]; 0 = first received bit lands in p_data[7].

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous flush of the partial frame.
- s_valid  input  1  serial bit present.
- s_data  input  1  serial bit value.
- s_ready  output  1  receiver can accept a bit this cycle.
- p_valid  output  1  p_data holds an unconsumed byte.
- p_ready  input  1  consumer takes byte when p_valid & p_ready.
- p_data  output  8  assembled byte.
- p_perr  output  1  parity error flag for p_data (see Optional Feature).
- bit_cnt  output  4  bits accepted in the current frame.

Behaviour:
- Reset (async, immediate): shift reg 0, bit_cnt 0, state SHIFT, p_data 0x00, p_valid 0, p_perr 0, s_ready 1.
- States:
  - SHIFT: collecting bits. s_ready = 1.
  - HOLD: full frame parked in shift reg, output stage occupied. s_ready = 0.
- Bit accept: s_valid & s_ready at a rising edge.
- Shift direction:
  - LSB_FIRST=1: shift right, new bit into bit 7.
  - LSB_FIRST=0: shift left, new bit into bit 0.
  - After 8 bits, the first bit sits at bit 0 for LSB_FIRST=1 and at bit 7 for LSB_FIRST=0.
- bit_cnt: increments per accept and wraps to 0 on the last bit of a frame. Frame length N = 8, or 9 with parity enabled.
- Output stage free: p_valid==0, or p_valid & p_ready in the same cycle.
- Last bit accepted, output free: at that same edge p_data <= completed byte, p_valid <= 1, state stays SHIFT. Latency from last bit accept to p_valid = 0 cycles (registered on the accept edge).
- Last bit accepted, output busy: byte stays in shift reg, state <= HOLD.
- HOLD exit: once output is free, next edge loads p_data, keeps p_valid 1, state <= SHIFT. Back-to-back p_ready gives a 1-byte-per-cycle drain with no bubble.
- p_valid clears at the edge where p_valid & p_ready and no new byte loads.
- p_data and p_perr are stable while p_valid & !p_ready.
- clear:
  - Sync; priority over a bit accept in the same cycle.
  - Zeroes shift reg and bit_cnt; state <= SHIFT.
  - Does NOT touch p_valid, p_data or p_perr. A byte parked in HOLD is discarded.
- s_valid low: no state change. Gaps of any length are allowed mid-frame.
- s_data ignored when s_ready == 0.

Optional Feature:
- Macro: SHIFTER8_DESER_PARITY_EN.
- Defined:
  - Frame = 8 data bits followed by 1 even-parity bit; N = 9, bit_cnt runs 0..8.
  - p_perr <= (XOR of 8 data bits) ^ parity bit; loaded together with p_data.
  - The parity bit is not stored in p_data.
- Undefined:
  - N = 8, bit_cnt runs 0..7, p_perr tied to 0.
  - Port list unchanged.

Test Plan:
- LSB_FIRST=1, p_ready=1, bits 1,0,1,0,0,1,0,1 on consecutive cycles -> p_data=0xA5, p_valid high for exactly 1 cycle starting at the 8th-bit edge, bit_cnt back to 0.
- LSB_FIRST=0, same bit stream -> p_data=0xA5 in reverse order, i.e. 0xA5 reversed = 0xA5; also send 0x01 LSB-first sequence -> p_data=0x80.
- p_ready=0, send 0x3C then 0xC3 -> p_data=0x3C held, state HOLD, s_ready=0. Raise p_ready 1 cycle -> p_data=0xC3 next edge, s_ready=1, no byte lost or duplicated.
- s_valid toggling 1,0,0,1 pattern over a 0x5A frame -> p_data=0x5A; bit_cnt only advances on accepted bits.
- 5 bits in, then clear=1 together with s_valid=1 -> bit_cnt=0, the clashing bit is dropped, next 8 bits give a clean byte. Async reset asserted mid-frame -> all outputs return to reset values without a clock edge.
- With SHIFTER8_DESER_PARITY_EN: 0xA5 + parity 0 -> p_perr=0. Same data + parity 1 -> p_perr=1, p_data=0xA5.
